phy_tx: RTL and testbench

//  Transmit side of the two-lane serial PHY. Accepts 32-bit words over valid/ready and

---
 rtl/phy_tx.sv | 103 ++++++++++
 tb/tb_phy_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx.sv
// phy_tx: transmit side of the two-lane serial PHY. Byte-stripes 32-bit words across
// two lanes, MSB first, one bit per clk, and fills idle time with the COMMA byte.
module phy_tx #(
  parameter logic [7:0] COMMA      = 8'hBC,
  parameter int         SYNC_BYTES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        serial_o0,
  output logic        serial_o1,
  output logic        active_out
);

  localparam int SW = (SYNC_BYTES > 1) ? $clog2(SYNC_BYTES) : 1;

  typedef enum logic [1:0] {SYNC, IDLE, DATA_HI, DATA_LO} state_t;

  state_t        r_state;
  logic [2:0]    r_bitCnt;
  logic [SW-1:0] r_syncCnt;
  logic [7:0]    r_shift0;
  logic [7:0]    r_shift1;
  logic [31:0]   r_buf;
  logic          r_bufFull;
  logic [15:0]   r_loHold;
  logic          r_active;

  logic w_bb;
  logic w_accept;

  assign w_bb       = (r_bitCnt == 3'd7);
  assign ready_out  = !r_bufFull && (r_state != SYNC);
  assign w_accept   = valid_in && ready_out;
  assign serial_o0  = r_shift0[7];
  assign serial_o1  = r_shift1[7];
  assign active_out = r_active;

  // Accept and hi-half load never coincide: accept needs an empty buffer, the load a full one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= SYNC;
      r_bitCnt  <= '0;
      r_syncCnt <= '0;
      r_shift0  <= COMMA;
      r_shift1  <= COMMA;
      r_buf     <= '0;
      r_bufFull <= 1'b0;
      r_loHold  <= '0;
      r_active  <= 1'b0;
    end else begin
      r_bitCnt <= r_bitCnt + 3'd1;

      if (w_accept) begin
        r_buf     <= data_in;
        r_bufFull <= 1'b1;
      end

      if (!w_bb) begin
        r_shift0 <= {r_shift0[6:0], 1'b0};
        r_shift1 <= {r_shift1[6:0], 1'b0};
      end else begin
        case (r_state)
          SYNC: begin
            r_shift0 <= COMMA;
            r_shift1 <= COMMA;
            r_active <= 1'b0;
            if (r_syncCnt == SW'(SYNC_BYTES - 1)) begin
              r_syncCnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_syncCnt <= r_syncCnt + SW'(1);
            end
          end
          IDLE, DATA_LO: begin
            if (r_bufFull) begin
              r_shift0  <= r_buf[31:24];
              r_shift1  <= r_buf[23:16];
              r_loHold  <= r_buf[15:0];
              r_bufFull <= 1'b0;
              r_active  <= 1'b1;
              r_state   <= DATA_HI;
            end else begin
              r_shift0 <= COMMA;
              r_shift1 <= COMMA;
              r_active <= 1'b0;
              r_state  <= IDLE;
            end
          end
          DATA_HI: begin
            r_shift0 <= r_loHold[15:8];
            r_shift1 <= r_loHold[7:0];
            r_active <= 1'b1;
            r_state  <= DATA_LO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phy_tx.sv
// tb_phy_tx: scoreboard bench for phy_tx. Accepted words queue their expected lane
// byte pairs; a lane monitor reassembles bytes and pops/compares them.
module tb_phy_tx;

  localparam logic [7:0] COMMA = 8'hBC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic        serial_o0;
  logic        serial_o1;
  logic        active_out;

  int checks = 0;
  int errors = 0;

  logic [15:0] expQ[$];
  logic [2:0]  phase = 3'd0;
  logic [7:0]  mon0 = '0;
  logic [7:0]  mon1 = '0;
  logic [15:0] expPair;
  logic        actStart = 1'b0;
  logic        prevAct = 1'b0;
  int          activeCnt = 0;
  int          dataBytes = 0;
  int          rises = 0;
  int          acceptCnt = 0;
  int          acceptPhase = 0;

  phy_tx dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .serial_o0  (serial_o0),
    .serial_o1  (serial_o1),
    .active_out (active_out)
  );

  always #5 clk = ~clk;

  // Bench-side byte phase: which bit of the current byte is on the lanes this cycle.
  always @(posedge clk) phase <= reset ? 3'd0 : phase + 3'd1;

  // Lane monitor: assemble one byte per lane every 8 cycles and score it.
  always @(negedge clk) begin
    mon0 = {mon0[6:0], serial_o0};
    mon1 = {mon1[6:0], serial_o1};
    if (active_out) activeCnt++;
    if (active_out && !prevAct) rises++;
    prevAct = active_out;
    if (phase == 3'd0) actStart = active_out;
    if (phase == 3'd7) begin
      checks++;
      if (active_out !== actStart) begin
        errors++;
        $display("[TB] FAIL active_steady: active=%b at byte end, %b at byte start", active_out, actStart);
      end
      checks++;
      if (active_out) begin
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_data: lanes %h/%h active with no word pending", mon0, mon1);
        end else begin
          expPair = expQ.pop_front();
          dataBytes++;
          if ({mon0, mon1} !== expPair) begin
            errors++;
            $display("[TB] FAIL lane_data: got %h/%h expected %h/%h", mon0, mon1, expPair[15:8], expPair[7:0]);
          end
        end
      end else if (mon0 !== COMMA || mon1 !== COMMA) begin
        errors++;
        $display("[TB] FAIL lane_comma: got %h/%h expected %h/%h", mon0, mon1, COMMA, COMMA);
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input int wantPhase);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      data_in = d;
      if (wantPhase < 0 || int'(phase) == wantPhase) begin
        valid_in = 1'b1;
        if (ready_out && !reset) begin
          expQ.push_back({d[31:24], d[23:16]});
          expQ.push_back({d[15:8], d[7:0]});
          acceptCnt++;
          acceptPhase = int'(phase);
          done = 1;
        end
      end else begin
        valid_in = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL accept_timeout: word %h not accepted, got 0 accepts expected 1", d);
    end
  endtask

  task automatic wait_drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (expQ.size() == 0 && !active_out) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL drain_timeout: %0d byte pairs pending, expected 0", expQ.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid_in = 1'b0;
    repeat (3) @(negedge clk);
    expQ.delete();
    checks++;
    if (serial_o0 !== 1'b1 || serial_o1 !== 1'b1 || ready_out !== 1'b0 || active_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: serial=%b%b ready=%b active=%b expected 11/0/0",
               serial_o0, serial_o1, ready_out, active_out);
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (ready_out !== logic'(i >= 32)) begin
        errors++;
        $display("[TB] FAIL sync_ready clk %0d: got %b expected %b", i, ready_out, (i >= 32));
      end
    end
  endtask

  task automatic test_single_word();
    int n = 0;
    int bytesBefore;
    bytesBefore = dataBytes;
    activeCnt = 0;
    send_word(32'hDEADBEEF, -1);
    wait_drain(64);
    repeat (10) @(negedge clk);
    checks++;
    if (activeCnt != 16) begin
      errors++;
      $display("[TB] FAIL active_len: got %0d clk expected 16", activeCnt);
    end
    checks++;
    if (dataBytes - bytesBefore != 2) begin
      errors++;
      $display("[TB] FAIL single_bytes: got %0d pairs expected 2", dataBytes - bytesBefore);
    end
  endtask

  task automatic test_latency();
    int phases[4] = '{0, 3, 6, 7};
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      int expN;
      send_word(32'h10203040 + 32'(k), phases[k]);
      expN = (acceptPhase == 7) ? 9 : 8 - acceptPhase;
      while (n < 20) begin
        @(negedge clk);
        valid_in = 1'b0;
        n++;
        if (active_out) break;
      end
      checks++;
      if (n != expN) begin
        errors++;
        $display("[TB] FAIL latency phase %0d: got %0d clk expected %0d", acceptPhase, n, expN);
      end
      wait_drain(64);
    end
  endtask

  task automatic test_back_to_back();
    int risesBefore = rises;
    int bytesBefore = dataBytes;
    send_word(32'h01234567, -1);
    send_word(32'h89ABCDEF, -1);
    wait_drain(100);
    checks++;
    if (rises - risesBefore != 1) begin
      errors++;
      $display("[TB] FAIL b2b_gap: got %0d data bursts expected 1", rises - risesBefore);
    end
    checks++;
    if (dataBytes - bytesBefore != 4) begin
      errors++;
      $display("[TB] FAIL b2b_bytes: got %0d pairs expected 4", dataBytes - bytesBefore);
    end
  endtask

  task automatic test_held_valid();
    int acceptsBefore = acceptCnt;
    int bytesBefore = dataBytes;
    int accepts;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      data_in = 32'hCAFEF00D;
      valid_in = 1'b1;
      if (ready_out && !reset) begin
        expQ.push_back(16'hCAFE);
        expQ.push_back(16'hF00D);
        acceptCnt++;
      end
    end
    wait_drain(100);
    accepts = acceptCnt - acceptsBefore;
    checks++;
    if (dataBytes - bytesBefore != 2 * accepts) begin
      errors++;
      $display("[TB] FAIL held_count: got %0d pairs expected %0d", dataBytes - bytesBefore, 2 * accepts);
    end
    checks++;
    if (accepts < 2 || accepts > 4) begin
      errors++;
      $display("[TB] FAIL held_accepts: got %0d expected 2..4", accepts);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    int risesBefore;
    int bytesBefore;
    send_word(32'h55AA33CC, -1);
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      valid_in = 1'b0;
      if (active_out) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL mid_start: active got 0 expected 1");
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    expQ.delete();
    checks++;
    if (serial_o0 !== 1'b1 || serial_o1 !== 1'b1 || ready_out !== 1'b0 || active_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_state: serial=%b%b ready=%b active=%b expected 11/0/0",
               serial_o0, serial_o1, ready_out, active_out);
    end
    @(negedge clk);
    risesBefore = rises;
    bytesBefore = dataBytes;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if (ready_out !== logic'(i >= 32)) begin
        errors++;
        $display("[TB] FAIL mid_ready clk %0d: got %b expected %b", i, ready_out, (i >= 32));
      end
    end
    repeat (16) @(negedge clk);
    checks++;
    if (rises != risesBefore || dataBytes != bytesBefore) begin
      errors++;
      $display("[TB] FAIL mid_remnant: got %0d bursts expected 0", rises - risesBefore);
    end
  endtask

  task automatic test_random_stream();
    int risesBefore = rises;
    int bytesBefore = dataBytes;
    for (int i = 0; i < 8; i++) send_word($urandom, -1);
    wait_drain(300);
    checks++;
    if (dataBytes - bytesBefore != 16) begin
      errors++;
      $display("[TB] FAIL stream_bytes: got %0d pairs expected 16", dataBytes - bytesBefore);
    end
    checks++;
    if (rises - risesBefore != 1) begin
      errors++;
      $display("[TB] FAIL stream_gap: got %0d bursts expected 1", rises - risesBefore);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] phy_tx bench start");
    test_reset();
    test_single_word();
    test_latency();
    test_back_to_back();
    test_held_valid();
    test_reset_mid();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
